// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a-b using one full-subtractor cell time-shared LSB first over WIDTH cycles
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_res, w_res;
    logic [CW-1:0] r_cnt;
    logic r_bor, w_d1, w_b1, w_d, w_b2, w_bout, w_last;
    assign w_d1   = r_a[0] ^ r_b[0];
    assign w_b1   = ~r_a[0] & r_b[0];
    assign w_d    = w_d1 ^ r_bor;
    assign w_b2   = ~w_d1 & r_bor;
    assign w_bout = w_b1 | w_b2;
    assign w_last = r_cnt == CW'(WIDTH - 1);
    assign w_res  = WIDTH'({w_d, r_res} >> 1);
    assign busy   = r_state != IDLE;
    assign done   = r_state == DONE;
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
                 (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_cnt      <= '0;
            r_bor      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_a   <= a;
            r_b   <= b;
            r_res <= '0;
            r_cnt <= '0;
            r_bor <= 1'b0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= w_res;
            r_bor <= w_bout;
            r_cnt <= w_last ? r_cnt : r_cnt + 1'b1;
            if (w_last) begin
                diff       <= w_res;
                borrow_out <= w_bout;
            end
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: random and directed checks of serial_sub_ctrl against a countdown/arithmetic model
module tb_serial_sub_ctrl;
    localparam int W = 8;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [W-1:0] a = '0, b = '0, diff;
    logic busy, done, borrow_out;
    int n_chk = 0, n_fail = 0, cyc = 0;
    bit chk_en = 1'b0;
    int m_left = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_diff = '0;
    logic m_bo = 1'b0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Model: a job occupies W+1 cycles after accept; the result is plain modular subtraction.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_left <= 0;
            m_diff <= '0;
            m_bo   <= 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                m_left <= W + 1;
                m_a    <= a;
                m_b    <= b;
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                m_diff <= W'(m_a - m_b);
                m_bo   <= m_a < m_b;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_left != 0);
            check("done", done, m_left == 1);
            check("diff", diff, m_diff);
            check("borrow_out", borrow_out, m_bo);
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < W + 4) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic op(input logic [W-1:0] xa, input logic [W-1:0] xb);
        int k = 0;
        wait_idle();
        a = xa;
        b = xb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_at_accept", busy, 1);
        while (!done && k < W + 4) begin
            @(negedge clk);
            k++;
            if (!done) check("busy_in_run", busy, 1);
        end
        check("latency", k, W);
    endtask

    initial begin
        int prev, gap, dn;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bo", borrow_out, 0);

        op(8'd100, 8'd37);
        check("d_100_37", diff, 63);
        check("b_100_37", borrow_out, 0);
        op(8'd37, 8'd100);
        check("d_37_100", diff, 8'hC1);
        check("b_37_100", borrow_out, 1);
        op(8'h00, 8'h01);
        check("d_0_1", diff, 8'hFF);
        check("b_0_1", borrow_out, 1);
        op(8'hFF, 8'h00);
        check("d_ff_0", diff, 8'hFF);
        check("b_ff_0", borrow_out, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);

        wait_idle();
        start = 1'b1;
        prev = -1;
        dn = 0;
        for (int i = 0; i < 5 * (W + 2); i++) begin
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            if (done) begin
                if (prev >= 0) begin
                    gap = cyc - prev;
                    check("held_gap", gap, W + 2);
                end
                prev = cyc;
                dn++;
            end
        end
        check("held_jobs", dn >= 4, 1);
        start = 1'b0;
        wait_idle();

        a = 8'd200;
        b = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_bo", borrow_out, 0);
        dn = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort_no_done", dn, 0);
        op(8'd200, 8'd1);
        check("d_200_1", diff, 199);
        check("b_200_1", borrow_out, 0);

        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            op(W'($urandom), W'($urandom));
        end
        wait_idle();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
